board_b_pixel_mixer: RTL and testbench
======================================

# board_b_pixel_mixer

Back end of the tile-layer pixel interface. Takes the per-pixel pen/colour/priority outputs (BIT, COL, CP15, CP8) of two background layers (A in front of B) plus the sprite pixel, and resolves priority into one 10-bit palette index. It then looks the index up in a CPU-writable palette RAM and drives registered 5:5:5 RGB with blanking to the video output stage.

## Interface
Parameters:
- PAL_AW, 10, palette address width (1024 entries)
- BACKDROP_IDX, 10'h000, palette index used when no source is opaque

Ports:
- CLK_32M  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- CE_PIX  in  1  pixel enable, one CLK_32M cycle wide
- A_BIT, A_COL  in  4,4  layer A pen, colour bank
- A_CP15, A_CP8  in  1,1  layer A priority flags
- B_BIT, B_COL, B_CP15, B_CP8  in  4,4,1,1  layer B, same meaning
- OBJ_PIX, OBJ_COL  in  4,4  sprite pen, colour bank
- A_EN, B_EN, OBJ_EN  in  1 each  source enables; a disabled source counts as transparent
- HBLANK, VBLANK  in  1,1  blanking for the pixel presented this CE_PIX
- DIN  in  16  CPU write data
- DOUT  out  16  CPU read data
- A  in  10  CPU word address into the palette
- BYTE_SEL  in  2  byte lanes
- RD, WR  in  1,1  CPU strobes, one clock wide
- R, G, B  out  5 each  pixel colour
- HBLANK_O, VBLANK_O  out  1,1  blanking aligned to RGB

## Operation
- Opaque: pen != 0 and the source is enabled.
- Layer "front": opaque and (CPx15, or CPx8 with pen[3]=1). Otherwise "back".
- Priority, highest first: A front, B front, sprite opaque, A back, B back, backdrop.
- Index = {src[1:0], col[3:0], pen[3:0]}, with src: sprite=0, A=1, B=2. The backdrop uses BACKDROP_IDX.
- Palette word layout: [14:10] B, [9:5] G, [4:0] R. Bit 15 is stored and read back but does not affect output.
- CPU write: lanes are written per BYTE_SEL in the same clock as WR.
- CPU read: DOUT is registered and valid the clock after RD. DOUT holds its value otherwise.
- Blanked pixel: RGB is forced to 0. The palette is still read.
- All outputs reset to 0: R, G, B, DOUT, HBLANK_O, VBLANK_O.

## Timing
- Stage 1, on CE_PIX: register the resolved index and the blanking inputs.
- Stage 2: the palette video port is addressed from the stage-1 index. Data returns on the next CLK_32M.
- Stage 3, on the next CE_PIX: register RGB and blanking.
- Total latency: 2 CE_PIX pixels from inputs to RGB. Blanking outputs carry the identical delay.
- RGB changes only on CE_PIX edges.
- Palette RAM is true dual-port: CPU port and video port are independent with no stalls.
- Same-address CPU write and video read in one clock: the video port returns the old data. The new value is visible from the next read.
- WR and RD asserted together: the write happens, and DOUT returns the pre-write data.
- Reset asserted mid-frame: pipeline registers and outputs clear immediately. Palette contents are undefined and are not cleared.
- After reset release, the first valid RGB appears on the 2nd CE_PIX.
- CE_PIX may be held low indefinitely (pause): outputs hold.

## Structure
- Package board_b_mixer_pkg holds:
  - enum src_t {SRC_OBJ=0, SRC_A=1, SRC_B=2}
  - the palette word field positions
  - a function returning a pixel's front/back/opaque class
- Sub-module mixer_palette_ram: 1024x16 dual-port RAM with byte-lane write on port A and read-only port B, both clocked by CLK_32M.
- Priority resolution is combinational inside the top module, with no further hierarchy.

## Test plan
- Palette write/readback: WR A=10'h155, DIN=16'h7FFF, BYTE_SEL=2'b01, then BYTE_SEL=2'b10 with DIN=16'h1200. RD then gives DOUT=16'h12FF one clock later.
- Priority and latency: A_BIT=3, A_CP8=1 (back), OBJ_PIX=5, OBJ_COL=2, palette[10'h025]=16'h001F. After 2 CE_PIX, R=31, G=0, B=0. Then set A_BIT=9 with A_CP8=1: index becomes 10'h109 (A front) after 2 pixels.
- Transparency and enables: all pens 0 gives BACKDROP_IDX colour. With A_BIT=4 and A_CP15=1 but A_EN=0, B or the sprite wins.
- Blanking: HBLANK=1 with an opaque pixel gives RGB=0 and HBLANK_O=1 exactly 2 pixels later.
- Collision: a CPU write to index 10'h109 in the same clock as the video read of 10'h109 shows the old colour for that pixel and the new colour on the next pixel using 10'h109.
- Reset: assert reset_n=0 between CE_PIX pulses. RGB, DOUT and the blanking outputs read 0 asynchronously and resume after 2 CE_PIX.

Source files
------------

// File: rtl/board_b_mixer_pkg.sv
// Shared types and helpers for the board B pixel mixer: source codes, palette
// word field positions and the per-layer pixel classification.
package board_b_mixer_pkg;

    typedef enum logic [1:0] {
        SRC_OBJ = 2'd0,
        SRC_A   = 2'd1,
        SRC_B   = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        PIX_TRANSP = 2'd0,
        PIX_BACK   = 2'd1,
        PIX_FRONT  = 2'd2
    } pix_class_t;

    localparam int PAL_R_LSB = 0;
    localparam int PAL_G_LSB = 5;
    localparam int PAL_B_LSB = 10;
    localparam int PAL_CH_W  = 5;

    // A disabled or pen-0 pixel is transparent; CP8 only promotes pens 8..15.
    function automatic pix_class_t pix_class(input logic [3:0] pen, input logic en,
                                             input logic cp15, input logic cp8);
        if (!en || pen == 4'd0)
            return PIX_TRANSP;
        if (cp15 || (cp8 && pen[3]))
            return PIX_FRONT;
        return PIX_BACK;
    endfunction

    function automatic logic [9:0] pal_index(input src_t src, input logic [3:0] col,
                                             input logic [3:0] pen);
        return {src, col, pen};
    endfunction

endpackage

// File: rtl/mixer_palette_ram.sv
// 16-bit dual-port palette RAM: byte-lane write/read CPU port, read-only video
// port. Both reads are registered and return pre-write data on collisions.
module mixer_palette_ram #(
    parameter int AW = 10
) (
    input  logic          CLK_32M,
    input  logic [AW-1:0] a_addr,
    input  logic [15:0]   a_din,
    input  logic [1:0]    a_be,
    input  logic          a_wr,
    input  logic          a_rd,
    output logic [15:0]   a_dout,
    input  logic [AW-1:0] b_addr,
    input  logic          b_rd,
    output logic [15:0]   b_dout
);

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] a_dout_reg;
    logic [15:0] b_dout_reg;

    always_ff @(posedge CLK_32M) begin
        if (a_wr) begin
            for (int lane = 0; lane < 2; lane++) begin
                if (a_be[lane])
                    mem[a_addr][8*lane +: 8] <= a_din[8*lane +: 8];
            end
        end
        if (a_rd)
            a_dout_reg <= mem[a_addr];
    end

    always_ff @(posedge CLK_32M) begin
        if (b_rd)
            b_dout_reg <= mem[b_addr];
    end

    assign a_dout = a_dout_reg;
    assign b_dout = b_dout_reg;

endmodule

// File: rtl/board_b_pixel_mixer.sv
// Resolves layer A / layer B / sprite priority into a palette index, looks it
// up in the palette RAM and drives registered 5:5:5 RGB with aligned blanking.
module board_b_pixel_mixer
    import board_b_mixer_pkg::*;
#(
    parameter int         PAL_AW       = 10,
    parameter logic [9:0] BACKDROP_IDX = 10'h000
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic              CE_PIX,
    input  logic [3:0]        A_BIT,
    input  logic [3:0]        A_COL,
    input  logic              A_CP15,
    input  logic              A_CP8,
    input  logic [3:0]        B_BIT,
    input  logic [3:0]        B_COL,
    input  logic              B_CP15,
    input  logic              B_CP8,
    input  logic [3:0]        OBJ_PIX,
    input  logic [3:0]        OBJ_COL,
    input  logic              A_EN,
    input  logic              B_EN,
    input  logic              OBJ_EN,
    input  logic              HBLANK,
    input  logic              VBLANK,
    input  logic [15:0]       DIN,
    output logic [15:0]       DOUT,
    input  logic [PAL_AW-1:0] A,
    input  logic [1:0]        BYTE_SEL,
    input  logic              RD,
    input  logic              WR,
    output logic [4:0]        R,
    output logic [4:0]        G,
    output logic [4:0]        B,
    output logic              HBLANK_O,
    output logic              VBLANK_O
);

    pix_class_t  a_cls, b_cls, obj_cls;
    logic [9:0]  idx_next;

    logic [9:0]  idx_reg;
    logic        hb1_reg, vb1_reg;
    logic        pix_valid_reg;
    logic        ce_d_reg;
    logic        dout_live_reg;
    logic [4:0]  r_reg, g_reg, b_reg;
    logic        hbo_reg, vbo_reg;

    logic [15:0] cpu_rdata;
    logic [15:0] vid_word;

    assign a_cls   = pix_class(A_BIT, A_EN, A_CP15, A_CP8);
    assign b_cls   = pix_class(B_BIT, B_EN, B_CP15, B_CP8);
    // Sprites carry no priority flags, so they can only ever be back or transparent.
    assign obj_cls = pix_class(OBJ_PIX, OBJ_EN, 1'b0, 1'b0);

    always_comb begin
        idx_next = BACKDROP_IDX;
        if (a_cls == PIX_FRONT)
            idx_next = pal_index(SRC_A, A_COL, A_BIT);
        else if (b_cls == PIX_FRONT)
            idx_next = pal_index(SRC_B, B_COL, B_BIT);
        else if (obj_cls != PIX_TRANSP)
            idx_next = pal_index(SRC_OBJ, OBJ_COL, OBJ_PIX);
        else if (a_cls == PIX_BACK)
            idx_next = pal_index(SRC_A, A_COL, A_BIT);
        else if (b_cls == PIX_BACK)
            idx_next = pal_index(SRC_B, B_COL, B_BIT);
    end

    // The video port reads exactly once per pixel, the clock after CE_PIX, so a
    // colliding CPU write is seen by the following pixel and not this one.
    mixer_palette_ram #(
        .AW(PAL_AW)
    ) u_pal (
        .CLK_32M (CLK_32M),
        .a_addr  (A),
        .a_din   (DIN),
        .a_be    (BYTE_SEL),
        .a_wr    (WR),
        .a_rd    (RD),
        .a_dout  (cpu_rdata),
        .b_addr  (idx_reg[PAL_AW-1:0]),
        .b_rd    (ce_d_reg),
        .b_dout  (vid_word)
    );

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg       <= '0;
            hb1_reg       <= 1'b0;
            vb1_reg       <= 1'b0;
            pix_valid_reg <= 1'b0;
            ce_d_reg      <= 1'b0;
            dout_live_reg <= 1'b0;
            r_reg         <= '0;
            g_reg         <= '0;
            b_reg         <= '0;
            hbo_reg       <= 1'b0;
            vbo_reg       <= 1'b0;
        end else begin
            ce_d_reg <= CE_PIX;
            if (RD)
                dout_live_reg <= 1'b1;
            if (CE_PIX) begin
                idx_reg       <= idx_next;
                hb1_reg       <= HBLANK;
                vb1_reg       <= VBLANK;
                pix_valid_reg <= 1'b1;
                hbo_reg       <= hb1_reg;
                vbo_reg       <= vb1_reg;
                // The first pixel after reset has no palette data behind it yet.
                if (!pix_valid_reg || hb1_reg || vb1_reg) begin
                    r_reg <= '0;
                    g_reg <= '0;
                    b_reg <= '0;
                end else begin
                    r_reg <= vid_word[PAL_R_LSB +: PAL_CH_W];
                    g_reg <= vid_word[PAL_G_LSB +: PAL_CH_W];
                    b_reg <= vid_word[PAL_B_LSB +: PAL_CH_W];
                end
            end
        end
    end

    // The read register lives in the RAM and cannot reset, so mask it until the first read.
    assign DOUT     = dout_live_reg ? cpu_rdata : 16'h0000;
    assign R        = r_reg;
    assign G        = g_reg;
    assign B        = b_reg;
    assign HBLANK_O = hbo_reg;
    assign VBLANK_O = vbo_reg;

endmodule

// File: tb/tb_board_b_pixel_mixer.sv
// Self-checking bench for board_b_pixel_mixer: directed steps plus randomized
// pixels compared against a rule-level priority/palette model.
module tb_board_b_pixel_mixer;

    logic        CLK_32M = 1'b0;
    logic        reset_n = 1'b0;
    logic        CE_PIX = 1'b0;
    logic [3:0]  A_BIT = '0, A_COL = '0, B_BIT = '0, B_COL = '0, OBJ_PIX = '0, OBJ_COL = '0;
    logic        A_CP15 = 0, A_CP8 = 0, B_CP15 = 0, B_CP8 = 0;
    logic        A_EN = 1, B_EN = 1, OBJ_EN = 1, HBLANK = 0, VBLANK = 0;
    logic [15:0] DIN = '0;
    logic [15:0] DOUT;
    logic [9:0]  A = '0;
    logic [1:0]  BYTE_SEL = '0;
    logic        RD = 0, WR = 0;
    logic [4:0]  R, G, B;
    logic        HBLANK_O, VBLANK_O;

    board_b_pixel_mixer #(.PAL_AW(10), .BACKDROP_IDX(10'h000)) dut (
        .CLK_32M(CLK_32M), .reset_n(reset_n), .CE_PIX(CE_PIX),
        .A_BIT(A_BIT), .A_COL(A_COL), .A_CP15(A_CP15), .A_CP8(A_CP8),
        .B_BIT(B_BIT), .B_COL(B_COL), .B_CP15(B_CP15), .B_CP8(B_CP8),
        .OBJ_PIX(OBJ_PIX), .OBJ_COL(OBJ_COL),
        .A_EN(A_EN), .B_EN(B_EN), .OBJ_EN(OBJ_EN),
        .HBLANK(HBLANK), .VBLANK(VBLANK),
        .DIN(DIN), .DOUT(DOUT), .A(A), .BYTE_SEL(BYTE_SEL), .RD(RD), .WR(WR),
        .R(R), .G(G), .B(B), .HBLANK_O(HBLANK_O), .VBLANK_O(VBLANK_O)
    );

    always #5 CLK_32M = ~CLK_32M;

    typedef struct packed {
        logic [4:0] r, g, b;
        logic       hb, vb;
    } pix_t;

    logic [15:0] pal [0:1023];
    pix_t        exp_prev = '0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Priority straight from the rules: A front, B front, sprite, A back, B back, backdrop.
    function automatic logic [9:0] ref_index();
        bit a_op = A_EN && (A_BIT != 0);
        bit b_op = B_EN && (B_BIT != 0);
        bit o_op = OBJ_EN && (OBJ_PIX != 0);
        bit a_fr = a_op && (A_CP15 || (A_CP8 && A_BIT >= 8));
        bit b_fr = b_op && (B_CP15 || (B_CP8 && B_BIT >= 8));
        if (a_fr) return 10'(256 + A_COL * 16 + A_BIT);
        if (b_fr) return 10'(512 + B_COL * 16 + B_BIT);
        if (o_op) return 10'(OBJ_COL * 16 + OBJ_PIX);
        if (a_op) return 10'(256 + A_COL * 16 + A_BIT);
        if (b_op) return 10'(512 + B_COL * 16 + B_BIT);
        return 10'h000;
    endfunction

    function automatic pix_t model_pixel();
        pix_t p;
        logic [15:0] w = pal[ref_index()];
        bit blank = HBLANK || VBLANK;
        p.r  = blank ? 5'd0 : w[4:0];
        p.g  = blank ? 5'd0 : w[9:5];
        p.b  = blank ? 5'd0 : w[14:10];
        p.hb = HBLANK;
        p.vb = VBLANK;
        return p;
    endfunction

    task automatic cpu_write(input logic [9:0] addr, input logic [15:0] data, input logic [1:0] sel);
        @(negedge CLK_32M);
        A = addr; DIN = data; BYTE_SEL = sel; WR = 1;
        @(negedge CLK_32M);
        WR = 0;
        if (sel[0]) pal[addr][7:0]  = data[7:0];
        if (sel[1]) pal[addr][15:8] = data[15:8];
    endtask

    task automatic cpu_read(input logic [9:0] addr, input string tag);
        logic [15:0] expv = pal[addr];
        @(negedge CLK_32M);
        A = addr; RD = 1;
        @(negedge CLK_32M);
        RD = 0;
        chk(tag, 32'(DOUT), 32'(expv));
        $display("[TB] read  addr=%03h dout=%04h", addr, DOUT);
    endtask

    // One pixel: CE_PIX for one clock, then three idle clocks. Optionally a CPU
    // write lands on the clock the video port reads this pixel's index.
    task automatic do_pixel(input bit do_wr, input logic [9:0] waddr, input logic [15:0] wdata);
        pix_t cur = model_pixel();
        @(negedge CLK_32M);
        CE_PIX = 1;
        @(negedge CLK_32M);
        CE_PIX = 0;
        chk("pix", 32'({R, G, B, HBLANK_O, VBLANK_O}), 32'(exp_prev));
        $display("[TB] pixel idx=%03h rgb=%0d/%0d/%0d hb=%0b vb=%0b", ref_index(), R, G, B, HBLANK_O, VBLANK_O);
        exp_prev = cur;
        if (do_wr) begin
            A = waddr; DIN = wdata; BYTE_SEL = 2'b11; WR = 1;
            @(negedge CLK_32M);
            WR = 0;
            pal[waddr] = wdata;
        end else begin
            @(negedge CLK_32M);
        end
        @(negedge CLK_32M);
    endtask

    task automatic set_layers(input logic [3:0] abit, input logic [3:0] acol, input logic a15, input logic a8,
                              input logic [3:0] bbit, input logic [3:0] bcol, input logic b15, input logic b8,
                              input logic [3:0] opix, input logic [3:0] ocol);
        A_BIT = abit; A_COL = acol; A_CP15 = a15; A_CP8 = a8;
        B_BIT = bbit; B_COL = bcol; B_CP15 = b15; B_CP8 = b8;
        OBJ_PIX = opix; OBJ_COL = ocol;
    endtask

    function automatic logic [3:0] rnd_pen();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
    endfunction

    initial begin
        pix_t shown;
        // Reset state
        #1;
        chk("rst_R", 32'(R), 0);
        chk("rst_DOUT", 32'(DOUT), 0);
        chk("rst_HBLANK_O", 32'(HBLANK_O), 0);
        chk("rst_VBLANK_O", 32'(VBLANK_O), 0);
        repeat (3) @(negedge CLK_32M);
        reset_n = 1;

        for (int i = 0; i < 1024; i++)
            cpu_write(10'(i), 16'($urandom), 2'b11);

        // Byte-lane write then readback
        cpu_write(10'h155, 16'h7FFF, 2'b01);
        cpu_write(10'h155, 16'h1200, 2'b10);
        cpu_read(10'h155, "byte_lane_model");
        chk("byte_lane_const", 32'(DOUT), 32'h12FF);
        repeat (3) @(negedge CLK_32M);
        chk("dout_hold", 32'(DOUT), 32'h12FF);

        // WR and RD together: DOUT is the pre-write value
        @(negedge CLK_32M);
        A = 10'h155; DIN = 16'hABCD; BYTE_SEL = 2'b11; WR = 1; RD = 1;
        @(negedge CLK_32M);
        WR = 0; RD = 0;
        chk("wr_rd_old", 32'(DOUT), 32'h12FF);
        pal[10'h155] = 16'hABCD;
        cpu_read(10'h155, "wr_rd_new");

        // Sprite beats A back, then A front wins
        cpu_write(10'h025, 16'h001F, 2'b11);
        A_EN = 1; B_EN = 1; OBJ_EN = 1; HBLANK = 0; VBLANK = 0;
        set_layers(4'd3, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 4'd2);
        do_pixel(0, '0, '0);
        set_layers(4'd9, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 4'd2);
        do_pixel(0, '0, '0);
        chk("prio_R31", 32'(R), 31);
        chk("prio_G0", 32'(G), 0);
        chk("prio_B0", 32'(B), 0);
        do_pixel(0, '0, '0);

        // Backdrop, then a disabled front A
        set_layers(4'd0, 4'd3, 1, 1, 4'd0, 4'd1, 1, 1, 4'd0, 4'd7);
        do_pixel(0, '0, '0);
        A_EN = 0;
        set_layers(4'd4, 4'd1, 1, 0, 4'd6, 4'd2, 0, 0, 4'd0, 4'd0);
        do_pixel(0, '0, '0);
        set_layers(4'd4, 4'd1, 1, 0, 4'd6, 4'd2, 0, 0, 4'd3, 4'd5);
        do_pixel(0, '0, '0);
        A_EN = 1;

        // Blanking of an opaque pixel
        HBLANK = 1;
        set_layers(4'd9, 4'd0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
        do_pixel(0, '0, '0);
        HBLANK = 0;
        do_pixel(0, '0, '0);
        chk("blank_HBLANK_O", 32'(HBLANK_O), 1);
        chk("blank_rgb0", 32'({R, G, B}), 0);

        // Collision on index 0x109
        cpu_write(10'h109, 16'h0421, 2'b11);
        set_layers(4'd9, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
        do_pixel(1, 10'h109, 16'h7C00);
        do_pixel(0, '0, '0);
        chk("coll_old_B", 32'(B), 1);
        do_pixel(0, '0, '0);
        chk("coll_new_B", 32'(B), 31);

        // Randomized pixels
        for (int n = 0; n < 300; n++) begin
            set_layers(rnd_pen(), 4'($urandom), 1'($urandom), 1'($urandom),
                       rnd_pen(), 4'($urandom), 1'($urandom), 1'($urandom),
                       rnd_pen(), 4'($urandom));
            A_EN = ($urandom_range(0, 3) != 0);
            B_EN = ($urandom_range(0, 3) != 0);
            OBJ_EN = ($urandom_range(0, 3) != 0);
            HBLANK = ($urandom_range(0, 7) == 0);
            VBLANK = ($urandom_range(0, 11) == 0);
            do_pixel(0, '0, '0);
        end

        // Pause: CE_PIX low, inputs wandering, outputs hold
        shown = exp_prev;
        do_pixel(0, '0, '0);
        shown = exp_prev;
        do_pixel(0, '0, '0);
        shown = {R, G, B, HBLANK_O, VBLANK_O};
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK_32M);
            set_layers(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                       4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                       4'($urandom), 4'($urandom));
            HBLANK = 1'($urandom);
        end
        chk("pause_hold", 32'({R, G, B, HBLANK_O, VBLANK_O}), 32'(shown));

        // Reset mid-frame, outputs clear at once and resume after 2 pixels
        A_EN = 1; B_EN = 1; OBJ_EN = 1; HBLANK = 0; VBLANK = 1;
        set_layers(4'd9, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
        do_pixel(0, '0, '0);
        cpu_read(10'h109, "pre_rst_read");
        @(negedge CLK_32M);
        #2 reset_n = 0;
        #1;
        chk("midrst_rgb", 32'({R, G, B}), 0);
        chk("midrst_DOUT", 32'(DOUT), 0);
        chk("midrst_VBLANK_O", 32'(VBLANK_O), 0);
        @(negedge CLK_32M);
        reset_n = 1;
        exp_prev = '0;
        HBLANK = 0; VBLANK = 0;
        do_pixel(0, '0, '0);
        do_pixel(0, '0, '0);
        chk("resume_B", 32'(B), 31);
        for (int n = 0; n < 20; n++) begin
            set_layers(rnd_pen(), 4'($urandom), 1'($urandom), 1'($urandom),
                       rnd_pen(), 4'($urandom), 1'($urandom), 1'($urandom),
                       rnd_pen(), 4'($urandom));
            do_pixel(0, '0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
